// File: rtl/sha256_iter.sv
// sha256_iter -- iterative multi-block SHA-256 compression engine.
//
// ROUNDS_PER_CYCLE (1, 2, 4 or 8) rounds are evaluated per clock. The
// chaining value is kept between blocks, so a message is any number of
// pre-padded 512-bit blocks. A block is accepted in IDLE. RUN then lasts
// 64/ROUNDS_PER_CYCLE cycles. FINAL folds the working state into the chaining
// value, and hash_valid strobes in the following (IDLE) cycle.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   blk_valid   source presents a block (hold until accepted)
//   blk_ready   engine can accept a block (high in IDLE)
//   blk_data    pre-padded block, [0:511], bit 0 = MSB of word 0
//   blk_first   block starts a new message (load IV), sampled with the block
//   mode224     (SHA224_EN only) select SHA-224 IV, sampled when blk_first=1
//   busy        compression in progress (RUN or FINAL)
//   hash_valid  one-cycle strobe: hash was just updated
//   hash        chaining value / digest, [0:255], H0 in bits 0..31
//
// Build option
//   `define SHA224_EN adds the mode224 port and SHA-224 support. With SHA-224
//   active, hash bits 224..255 read 0. H7 is still kept internally for chaining.

module sha256_iter #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           blk_valid,
   output logic           blk_ready,
   input  logic [0:511]   blk_data,
   input  logic           blk_first,
`ifdef SHA224_EN
   input  logic           mode224,
`endif
   output logic           busy,
   output logic           hash_valid,
   output logic [0:255]   hash
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
         ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
      $error("sha256_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   localparam logic [5:0] RPC6     = 6'(ROUNDS_PER_CYCLE);
   localparam logic [5:0] LAST_CNT = 6'(64 - ROUNDS_PER_CYCLE);

   localparam logic [0:7][31:0] IV256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [0:7][31:0] IV224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [0:7][31:0] iv_of(input logic m224);
      return m224 ? IV224 : IV256;
   endfunction

   // Chained rounds: round r uses K[base+r] and window word r.
   // Index 0 of the state is 'a', index 7 is 'h'.
   function automatic logic [0:7][31:0] do_rounds(input logic [0:7][31:0] s,
                                                  input logic [0:15][31:0] win,
                                                  input logic [5:0] base);
      logic [0:7][31:0] v;
      logic [31:0]      t1;
      logic [31:0]      t2;
      v = s;
      for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
         t1 = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
              + K[base + 6'(r)] + win[r];
         t2 = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      return v;
   endfunction

   // Advance the 16-word window by ROUNDS_PER_CYCLE words. Later new words may
   // depend on earlier new words of the same cycle (x[14+j] for j >= 2).
   function automatic logic [0:15][31:0] next_window(input logic [0:15][31:0] win);
      logic [0:23][31:0] x;
      x = '0;
      x[0:15] = win;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
         x[16+j] = small_sigma1(x[14+j]) + x[9+j] + small_sigma0(x[1+j]) + x[j];
      return x[ROUNDS_PER_CYCLE +: 16];
   endfunction

   logic [1:0]        state;
   logic [5:0]        cnt;
   logic [0:7][31:0]  wv;
   logic [0:7][31:0]  hreg;
   logic [0:15][31:0] w;
   logic              base_iv;
   logic              mode_q;
   logic              mode_next;
   logic [0:7][31:0]  base;
   logic [0:7][31:0]  round_out;
   logic [0:15][31:0] win_next;

`ifdef SHA224_EN
   assign mode_next = blk_first ? mode224 : mode_q;
`else
   assign mode_next = 1'b0;
`endif

   assign blk_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   // The base for the final addition is either the chaining value or the IV.
   // The chaining value cannot change before FINAL, so only the choice is kept.
   assign base = base_iv ? iv_of(mode_q) : hreg;

   always_comb begin
      round_out = do_rounds(wv, w, cnt);
      win_next  = next_window(w);
   end

   always_comb begin
      hash = hreg;
      if (mode_q) hash[224:255] = 32'h0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         wv         <= '0;
         hreg       <= IV256;
         hash_valid <= 1'b0;
         base_iv    <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         hash_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (blk_valid) begin
                  wv      <= blk_first ? iv_of(mode_next) : hreg;
                  base_iv <= blk_first;
                  mode_q  <= mode_next;
                  cnt     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               wv  <= round_out;
               cnt <= cnt + RPC6;
               if (cnt == LAST_CNT) state <= S_FINAL;
            end
            S_FINAL: begin
               for (int i = 0; i < 8; i++) hreg[i] <= base[i] + wv[i];
               hash_valid <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Message window carries no reset: it is always loaded before use.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && blk_valid) w <= blk_data;
      else if (state == S_RUN)          w <= win_next;
   end

endmodule

// File: tb/tb_sha256_iter.sv
// tb_sha256_iter -- directed bench for sha256_iter. Four instances
// (ROUNDS_PER_CYCLE = 1, 2, 4, 8) are exercised one after another with
// known-answer blocks, a back-to-back second block, a held-valid handshake,
// and a reset pulled in the middle of RUN.

module tb_sha256_iter;

   localparam int NI = 4;

   localparam logic [0:511] ABC   = {32'h61626380, 416'h0, 64'h18};
   localparam logic [0:511] EMPTY = {32'h80000000, 480'h0};
   localparam logic [0:511] TWO1  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [0:511] TWO2  = {448'h0, 64'h1c0};

   localparam logic [255:0] IV_EXP  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_EXP = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMP_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_EXP = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [255:0] S224_EXP = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

   logic           clk = 1'b0;
   logic           reset;
   logic           vld   [NI];
   logic           first [NI];
   logic [0:511]   data  [NI];
   logic           rdy   [NI];
   logic           bsy   [NI];
   logic           hv    [NI];
   logic [0:255]   hs    [NI];
`ifdef SHA224_EN
   logic           m224  [NI];
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sha256_iter #(.ROUNDS_PER_CYCLE(1 << g)) dut (
         .clk        (clk),
         .reset      (reset),
         .blk_valid  (vld[g]),
         .blk_ready  (rdy[g]),
         .blk_data   (data[g]),
         .blk_first  (first[g]),
`ifdef SHA224_EN
         .mode224    (m224[g]),
`endif
         .busy       (bsy[g]),
         .hash_valid (hv[g]),
         .hash       (hs[g])
      );
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one block to instance k, wait for the accept, then wait for
   // hash_valid. Latency counts the accepting edge as edge 1. With hold set,
   // blk_valid stays high through RUN/FINAL and blk_ready must stay low.
   task automatic run_block(input int k, input logic [0:511] d, input logic f,
                            input bit hold, input string tag);
      int n;
      int rdy_hi;
      @(negedge clk);
      data[k]  = d;
      first[k] = f;
      vld[k]   = 1'b1;
      n = 0;
      while (!rdy[k] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " ready"}, 256'(rdy[k]), 256'(1'b1));
      @(posedge clk);
      #1;
      data[k]  = {16{32'hdeadbeef}};
      first[k] = ~f;
      if (!hold) vld[k] = 1'b0;
      n = 1;
      rdy_hi = 0;
      while (!hv[k] && n < 300) begin
         if (rdy[k]) rdy_hi++;
         @(posedge clk);
         #1;
         n++;
      end
      vld[k] = 1'b0;
      chk({tag, " latency"}, 256'(n), 256'(64 / (1 << k) + 2));
      if (hold) chk({tag, " ready during run"}, 256'(rdy_hi), 256'(0));
   endtask

   initial begin
      reset = 1'b0;
      for (int k = 0; k < NI; k++) begin
         vld[k] = 1'b0;
         first[k] = 1'b0;
         data[k] = '0;
`ifdef SHA224_EN
         m224[k] = 1'b0;
`endif
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rpc%0d reset ready", 1 << k), 256'(rdy[k]), 256'(1'b1));
         chk($sformatf("rpc%0d reset busy", 1 << k), 256'(bsy[k]), 256'(1'b0));
         chk($sformatf("rpc%0d reset hash_valid", 1 << k), 256'(hv[k]), 256'(1'b0));
         chk($sformatf("rpc%0d reset hash", 1 << k), hs[k], IV_EXP);
      end
      @(negedge clk);
      reset = 1'b1;

      // Known-answer blocks on every instance
      for (int k = 0; k < NI; k++) begin
         run_block(k, ABC, 1'b1, 1'b0, $sformatf("rpc%0d abc", 1 << k));
         chk($sformatf("rpc%0d abc digest", 1 << k), hs[k], ABC_EXP);
         run_block(k, EMPTY, 1'b1, 1'b0, $sformatf("rpc%0d empty", 1 << k));
         chk($sformatf("rpc%0d empty digest", 1 << k), hs[k], EMP_EXP);
         run_block(k, TWO1, 1'b1, 1'b0, $sformatf("rpc%0d two blk1", 1 << k));
         chk($sformatf("rpc%0d ready with hash_valid", 1 << k), 256'({rdy[k], hv[k]}), 256'(2'b11));
         run_block(k, TWO2, 1'b0, 1'b0, $sformatf("rpc%0d two blk2", 1 << k));
         chk($sformatf("rpc%0d two digest", 1 << k), hs[k], TWO_EXP);
         @(posedge clk);
         #1;
         chk($sformatf("rpc%0d hash_valid one cycle", 1 << k), 256'(hv[k]), 256'(1'b0));
      end

      // blk_valid held through RUN: no early accept, normal result
      run_block(0, ABC, 1'b1, 1'b1, "hold abc");
      chk("hold abc digest", hs[0], ABC_EXP);

      // Reset in the middle of RUN
      @(negedge clk);
      data[0] = EMPTY;
      first[0] = 1'b1;
      vld[0] = 1'b1;
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort busy before reset", 256'(bsy[0]), 256'(1'b1));
      #2;
      reset = 1'b0;
      #1;
      chk("abort ready", 256'(rdy[0]), 256'(1'b1));
      chk("abort busy", 256'(bsy[0]), 256'(1'b0));
      chk("abort hash_valid", 256'(hv[0]), 256'(1'b0));
      chk("abort hash", hs[0], IV_EXP);
      @(negedge clk);
      reset = 1'b1;
      run_block(0, ABC, 1'b1, 1'b0, "rehash abc");
      chk("rehash abc digest", hs[0], ABC_EXP);

      // First block after reset with blk_first=0 still starts from the IV
      run_block(1, ABC, 1'b0, 1'b0, "nofirst abc");
      chk("nofirst abc digest", hs[1], ABC_EXP);

`ifdef SHA224_EN
      m224[0] = 1'b1;
      run_block(0, ABC, 1'b1, 1'b0, "sha224 abc");
      m224[0] = 1'b0;
      chk("sha224 abc digest", hs[0], S224_EXP);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha256_iter.md
Name: sha256_iter

Overview:
- Iterative, multi-block SHA-256 compression engine.
- Successor to the fully unrolled single-block hasher. Rounds are folded into a round counter, with ROUNDS_PER_CYCLE rounds evaluated per clock.
- Chaining state is kept between blocks, so messages of any number of pre-padded 512-bit blocks can be hashed.
- Sits between a block source (UART receive / padding logic) and the hex-dump transmitter.

Parameters:
- ROUNDS_PER_CYCLE, 1: rounds per clock. Legal values are 1, 2, 4, 8. Any other value is a synthesis-time error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- blk_valid  in  1  source presents a block
- blk_ready  out  1  engine can accept a block
- blk_data  in  512  pre-padded message block, bit 0 = MSB of word 0 ([0:511] ordering)
- blk_first  in  1  block starts a new message (load IV); sampled with the block
- busy  out  1  compression in progress
- hash_valid  out  1  one-cycle strobe: hash updated
- hash  out  256  chaining value / digest, [0:255] ordering, H0 in bits 0..31

Behaviour:
- One clock domain (clk). reset is asynchronous and active-low.
- Reset values:
  - FSM in IDLE; blk_ready=1, busy=0, hash_valid=0.
  - hash = SHA-256 IV (6a09e667 … 5be0cd19).
  - Round counter = 0; working registers a..h = 0.
- Because hash resets to IV, a first block after reset with blk_first=0 still yields the correct digest.
- FSM states: IDLE, RUN, FINAL.
- IDLE:
  - blk_ready=1.
  - On blk_valid&blk_ready, latch blk_data into a 16-word W shift window.
  - Load a..h from IV if blk_first=1, otherwise from hash.
  - Clear the round counter; go to RUN.
  - blk_data and blk_first need not be held after the accepting edge.
- RUN:
  - blk_ready=0, busy=1.
  - Each cycle: apply ROUNDS_PER_CYCLE chained rounds using K[cnt..cnt+RPC-1] and W from the window.
  - Advance the window by RPC words, computing new W with σ0/σ1 schedule logic.
  - cnt += RPC.
  - When the rounds just applied include round 63, go to FINAL.
  - RUN lasts exactly 64/RPC cycles.
- FINAL:
  - busy=1.
  - hash[i] <= hash_or_IV[i] + a..h[i], 32-bit modulo addition per word. The base value is the one captured at accept.
  - Go to IDLE; hash_valid=1 for the following cycle only.
- Latency: hash_valid rises exactly 64/RPC+2 edges after the accepting edge. For RPC=1 that is 66.
- blk_ready and hash_valid are high together in the first IDLE cycle. A block accepted in that cycle is legal (back-to-back).
- Throughput: one block per 64/RPC+2 cycles.
- blk_valid is ignored while not in IDLE. Requests are neither dropped silently nor queued; the source must hold blk_valid until accepted.
- hash stays stable from hash_valid until the FINAL of the next block.
- Reset asserted mid-RUN or mid-FINAL aborts immediately to the reset values. No partial hash update is visible.
- All arithmetic is 32-bit wrap-around. Rotations are true rotations; σ shifts are logical.

Optional Feature:
- Macro: SHA224_EN.
- With the macro defined:
  - Extra input port mode224 (1 bit), sampled with the block when blk_first=1.
  - When set, the IV loaded is the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4).
  - The mode is held for every subsequent block of that message.
  - While the mode is active, hash bits 224..255 read 0; the internal H7 is still kept for chaining.
  - Reset clears the mode to SHA-256.
- Without the macro: no mode224 port; SHA-256 only.

Test Plan:
- Reset, then one block "abc" (616263 80 … 0…018) with blk_first=1 → hash_valid after 64/RPC+2 edges; hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (80 00… length 0), blk_first=1 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 with blk_first=1, block 2 with blk_first=0 accepted back-to-back in the hash_valid cycle → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Handshake and abort:
  - Hold blk_valid high during RUN → blk_ready stays 0 and no second accept occurs until IDLE.
  - Pull reset low mid-RUN → blk_ready=1, busy=0, hash_valid=0, hash = SHA-256 IV.
  - Re-hash "abc" → correct digest.
- Repeat the first three scenarios for ROUNDS_PER_CYCLE = 1, 2, 4, 8 → identical digests; latencies 66, 34, 18, 10 edges.
- With SHA224_EN, "abc", mode224=1 → 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, with bits 224..255 = 0.
